conc_trace_recorder: RTL and testbench

//  Response-side counterpart of the opcode stimulus driver in the concolic bench. The driver

---
 rtl/conc_trace_recorder_pkg.sv | 17 +
 rtl/conc_trace_recorder_fifo.sv | 55 +++++
 rtl/conc_trace_recorder.sv | 104 ++++++++++
 tb/tb_conc_trace_recorder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/conc_trace_recorder_pkg.sv
// Shared definitions for the trace recorder: FSM states and entry field layout.
package conc_trace_recorder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  // Entry layout is {run_len, value}; value sits in the low bits.
  localparam int VAL_LSB = 0;

  function automatic int run_lsb(input int data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/conc_trace_recorder_fifo.sv
// First-word fall-through FIFO; head is presented combinationally from the storage array.
module conc_trace_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  // When full, a simultaneous pop frees the head slot that the push then reuses.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/conc_trace_recorder.sv
// Run-length compresses a sampled response word into {run_len, value} entries and queues them.
module conc_trace_recorder
  import conc_trace_recorder_pkg::*;
#(
  parameter int DATA_W = 6,
  parameter int RUN_W  = 8,
  parameter int DEPTH  = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [DATA_W-1:0]         sample_in,
  input  logic                      rd_ready,
  output logic                      rd_valid,
  output logic [RUN_W+DATA_W-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  output logic                      busy
);

  localparam int RUN_LSB = run_lsb(DATA_W);
  localparam logic [RUN_W-1:0] RUN_MAX = {RUN_W{1'b1}};

  state_t                   state_reg, state_next;
  logic [DATA_W-1:0]        cur_val_reg, cur_val_next;
  logic [RUN_W-1:0]         run_reg, run_next;
  logic                     overflow_reg;
  logic                     push;
  logic                     pop;
  logic                     full;
  logic                     empty;
  logic [RUN_W+DATA_W-1:0]  entry;

  assign entry[RUN_LSB +: RUN_W] = run_reg;
  assign entry[VAL_LSB +: DATA_W] = cur_val_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      cur_val_reg  <= '0;
      run_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cur_val_reg <= cur_val_next;
      run_reg     <= run_next;
      if (push && full && !pop) overflow_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cur_val_next = cur_val_reg;
    run_next     = run_reg;
    push         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable) begin
          cur_val_next = sample_in;
          run_next     = RUN_W'(1);
          state_next   = RECORD;
        end
      end
      RECORD: begin
        if (!enable) begin
          state_next = FLUSH;
        end else if ((sample_in == cur_val_reg) && (run_reg != RUN_MAX)) begin
          run_next = run_reg + RUN_W'(1);
        end else begin
          // Value change or saturated run: close the current entry and start a fresh run.
          push         = 1'b1;
          cur_val_next = sample_in;
          run_next     = RUN_W'(1);
        end
      end
      FLUSH: begin
        push       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rd_valid = ~empty;
  assign pop      = rd_valid & rd_ready;
  assign overflow = overflow_reg;
  assign busy     = (state_reg != IDLE);

  conc_trace_fifo #(
    .WIDTH (RUN_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (entry),
    .dout  (rd_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

endmodule

// File: tb/tb_conc_trace_recorder.sv
// Self-checking bench for conc_trace_recorder: vector table, corner sequences, randomized sessions.
module tb_conc_trace_recorder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [5:0]  sample_in = 6'h0;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [13:0] rd_data;
  logic [4:0]  level;
  logic        overflow;
  logic        busy;

  int tests = 0;
  int fails = 0;
  logic [13:0] popped[$];

  typedef struct {
    logic        en;
    logic [5:0]  s;
    logic        rdy;
    logic        exp_valid;
    logic [13:0] exp_data;
    logic [4:0]  exp_level;
    logic        exp_busy;
  } vec_t;

  vec_t tbl[18];

  conc_trace_recorder #(.DATA_W(6), .RUN_W(8), .DEPTH(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .sample_in (sample_in),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .level     (level),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  // Inputs only change just after the rising edge, so at the falling edge a valid&ready pair means a pop next edge.
  always @(negedge clock) begin
    if (reset && rd_valid && rd_ready) popped.push_back(rd_data);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [13:0] ent(input int r, input int v);
    return {r[7:0], v[5:0]};
  endfunction

  task automatic drain(input string name);
    int n;
    n = 0;
    enable = 1'b0;
    rd_ready = 1'b1;
    while ((busy || rd_valid) && n < 200) begin
      step();
      n++;
    end
    chk(name, {31'd0, busy | rd_valid}, 32'd0);
    rd_ready = 1'b0;
  endtask

  initial begin
    logic [5:0]  samp[$];
    logic [13:0] expq[$];
    int          len;
    int          cnt;
    int          zero_runs;

    // Per-cycle vectors: one constant run of 5, then alternating values with a stalled consumer.
    for (int i = 0; i < 5; i++) tbl[i] = '{1'b1, 6'h15, 1'b0, 1'b0, 14'h0, 5'd0, 1'b1};
    tbl[5]  = '{1'b0, 6'h00, 1'b0, 1'b0, 14'h0, 5'd0, 1'b1};
    tbl[6]  = '{1'b0, 6'h00, 1'b0, 1'b1, ent(5, 'h15), 5'd1, 1'b0};
    tbl[7]  = '{1'b0, 6'h00, 1'b1, 1'b0, 14'h0, 5'd0, 1'b0};
    tbl[8]  = '{1'b1, 6'h01, 1'b0, 1'b0, 14'h0, 5'd0, 1'b1};
    tbl[9]  = '{1'b1, 6'h02, 1'b0, 1'b1, ent(1, 1), 5'd1, 1'b1};
    tbl[10] = '{1'b1, 6'h01, 1'b0, 1'b1, ent(1, 1), 5'd2, 1'b1};
    tbl[11] = '{1'b1, 6'h02, 1'b0, 1'b1, ent(1, 1), 5'd3, 1'b1};
    tbl[12] = '{1'b0, 6'h00, 1'b0, 1'b1, ent(1, 1), 5'd3, 1'b1};
    tbl[13] = '{1'b0, 6'h00, 1'b0, 1'b1, ent(1, 1), 5'd4, 1'b0};
    tbl[14] = '{1'b0, 6'h00, 1'b1, 1'b1, ent(1, 2), 5'd3, 1'b0};
    tbl[15] = '{1'b0, 6'h00, 1'b1, 1'b1, ent(1, 1), 5'd2, 1'b0};
    tbl[16] = '{1'b0, 6'h00, 1'b1, 1'b1, ent(1, 2), 5'd1, 1'b0};
    tbl[17] = '{1'b0, 6'h00, 1'b1, 1'b0, 14'h0, 5'd0, 1'b0};

    // T1: outputs stay cleared while reset is held, whatever the inputs do.
    for (int i = 0; i < 10; i++) begin
      enable = 1'($urandom);
      sample_in = 6'($urandom);
      rd_ready = 1'($urandom);
      step();
      chk("t1_reset_outputs", {10'd0, rd_valid, rd_data, level, overflow, busy}, 32'd0);
    end
    enable = 1'b0;
    rd_ready = 1'b0;
    reset = 1'b1;
    step();
    chk("t1_busy_after_release", {31'd0, busy}, 32'd0);
    chk("t1_valid_after_release", {31'd0, rd_valid}, 32'd0);

    // T2/T3: vector table.
    for (int i = 0; i < 18; i++) begin
      enable = tbl[i].en;
      sample_in = tbl[i].s;
      rd_ready = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d_valid", i), {31'd0, rd_valid}, {31'd0, tbl[i].exp_valid});
      chk($sformatf("vec%0d_data", i), {18'd0, rd_data}, {18'd0, tbl[i].exp_data});
      chk($sformatf("vec%0d_level", i), {27'd0, level}, {27'd0, tbl[i].exp_level});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].exp_busy});
    end
    rd_ready = 1'b0;

    // T4: 300 cycles of one value split at the maximum run length.
    popped.delete();
    rd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      enable = 1'b1;
      sample_in = 6'h2A;
      step();
    end
    drain("t4_drain_budget");
    chk("t4_entry_count", popped.size(), 32'd2);
    if (popped.size() == 2) begin
      chk("t4_entry0", {18'd0, popped[0]}, {18'd0, ent(255, 'h2A)});
      chk("t4_entry1", {18'd0, popped[1]}, {18'd0, ent(45, 'h2A)});
    end
    zero_runs = 0;
    foreach (popped[i]) if (popped[i][13:6] == 8'd0) zero_runs++;
    chk("t4_zero_runs", zero_runs, 32'd0);

    // T5: stalled consumer, 20 distinct samples -> 4 entries dropped.
    rd_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      enable = 1'b1;
      sample_in = 6'(i);
      step();
    end
    enable = 1'b0;
    step();
    step();
    chk("t5_level_full", {27'd0, level}, 32'd16);
    chk("t5_overflow", {31'd0, overflow}, 32'd1);
    chk("t5_busy_done", {31'd0, busy}, 32'd0);
    popped.delete();
    drain("t5_drain_budget");
    chk("t5_overflow_sticky", {31'd0, overflow}, 32'd1);
    chk("t5_entry_count", popped.size(), 32'd16);
    for (int i = 0; i < 16 && i < popped.size(); i++)
      chk($sformatf("t5_entry%0d", i), {18'd0, popped[i]}, {18'd0, ent(1, i)});
    reset = 1'b0;
    #1;
    chk("t5_overflow_cleared", {31'd0, overflow}, 32'd0);
    #1;
    reset = 1'b1;

    // T6: push and pop together while full, then reset in the middle of a record.
    for (int i = 0; i < 17; i++) begin
      enable = 1'b1;
      sample_in = 6'(i + 1);
      step();
    end
    chk("t6_level_full", {27'd0, level}, 32'd16);
    rd_ready = 1'b1;
    sample_in = 6'd40;
    step();
    chk("t6_level_kept", {27'd0, level}, 32'd16);
    chk("t6_no_overflow", {31'd0, overflow}, 32'd0);
    chk("t6_head_advanced", {18'd0, rd_data}, {18'd0, ent(1, 2)});
    rd_ready = 1'b0;
    step();
    chk("t6_busy_recording", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("t6_reset_level", {27'd0, level}, 32'd0);
    chk("t6_reset_valid", {31'd0, rd_valid}, 32'd0);
    chk("t6_reset_busy", {31'd0, busy}, 32'd0);
    chk("t6_reset_data", {18'd0, rd_data}, 32'd0);
    enable = 1'b0;
    #2;
    reset = 1'b1;
    step();
    step();
    chk("t6_run_lost", {26'd0, rd_valid, level}, 32'd0);

    // Randomized sessions against a run-length model of the enabled samples.
    for (int s = 0; s < 40; s++) begin
      len = $urandom_range(1, 12);
      samp.delete();
      for (int i = 0; i < len; i++) samp.push_back(6'($urandom_range(0, 3)));
      expq.delete();
      cnt = 0;
      for (int i = 0; i < len; i++) begin
        if (i == 0 || samp[i] != samp[i-1] || cnt == 255) begin
          if (i > 0) expq.push_back(ent(cnt, samp[i-1]));
          cnt = 1;
        end else begin
          cnt++;
        end
      end
      expq.push_back(ent(cnt, samp[len-1]));
      popped.delete();
      for (int i = 0; i < len; i++) begin
        enable = 1'b1;
        sample_in = samp[i];
        rd_ready = 1'($urandom_range(0, 1));
        step();
      end
      drain($sformatf("rnd%0d_drain_budget", s));
      chk($sformatf("rnd%0d_count", s), popped.size(), expq.size());
      for (int i = 0; i < expq.size() && i < popped.size(); i++)
        chk($sformatf("rnd%0d_entry%0d", s, i), {18'd0, popped[i]}, {18'd0, expq[i]});
    end
    chk("rnd_no_overflow", {31'd0, overflow}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
